// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the CPU datapath.
// master = sequencer side, slave = datapath / memory side.
interface multicycle_sequencer_if;
  logic [15:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        run;
  logic        step;

  logic        pc_we;
  logic        pc_src;
  logic        ir_we;
  logic        reg_we;
  logic [1:0]  reg_src;
  logic        alu_src;
  logic [1:0]  alu_ctrl;
  logic        mem_we;
  logic        mem_re;
  logic        mem_to_reg;
  logic [2:0]  state;
  logic        halted;
  logic        mem_err;
  logic        retired;

  // Memory handshake: mem_re/mem_we stay high through MEM until the cycle in which
  // mem_ready is seen; that cycle completes the transfer. No ready within the
  // timeout window drops the strobe and parks the sequencer in HALT with mem_err.
  modport master (
    input  instr, alu_flags, mem_ready, run, step,
    output pc_we, pc_src, ir_we, reg_we, reg_src, alu_src, alu_ctrl,
           mem_we, mem_re, mem_to_reg, state, halted, mem_err, retired
  );

  modport slave (
    output instr, alu_flags, mem_ready, run, step,
    input  pc_we, pc_src, ir_we, reg_we, reg_src, alu_src, alu_ctrl,
           mem_we, mem_re, mem_to_reg, state, halted, mem_err, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 8-bit / 16-bit-instruction CPU: FETCH, DECODE,
// EXEC, MEM, WB with per-state write enables, memory timeout and run/step control.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q;
  logic [3:0]  flags_q;
  logic [7:0]  wait_q;
  logic        step_pend_q;
  logic        mem_err_q;

  logic [2:0] op;
  logic [2:0] cond;
  logic       is_addi, is_ldr, is_str, is_b, is_hlt, is_mem, sets_flags;
  logic       flag_n, flag_z, flag_v;
  logic       br_taken;
  logic       wait_last;
  logic [2:0] done_next;

  assign op         = ir_q[15:13];
  assign cond       = ir_q[12:10];
  assign is_addi    = (op == 3'b100);
  assign is_ldr     = (op == 3'b101);
  assign is_str     = (op == 3'b110);
  assign is_b       = (op == 3'b111);
  assign is_hlt     = is_b && (cond == 3'b111);
  assign is_mem     = is_ldr || is_str;
  assign sets_flags = !op[2] || is_addi;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[0];

  // Register fields (dest/src/imm) and the carry flag feed the datapath, not control.
  logic unused_ok;
  assign unused_ok = ^{ir_q[9:0], flags_q[1]};

  // Conditions 101/110 never branch; 111 is HLT and never reaches EXEC.
  always_comb begin
    br_taken = 1'b0;
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = flag_z;
      3'b010:  br_taken = !flag_z;
      3'b011:  br_taken = (flag_n != flag_v);
      3'b100:  br_taken = (flag_n == flag_v);
      default: br_taken = 1'b0;
    endcase
  end

  assign wait_last = (wait_q == WAIT_LAST);
  assign done_next = bus.run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run || bus.step || step_pend_q) state_d = S_FETCH;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = is_hlt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_b)        state_d = done_next;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = is_ldr ? S_WB : done_next;
        else if (wait_last) state_d = S_HALT;
      end
      S_WB:     state_d = done_next;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      flags_q     <= '0;
      wait_q      <= '0;
      step_pend_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == S_FETCH) ir_q <= bus.instr;

      if (state_q == S_EXEC && sets_flags) flags_q <= bus.alu_flags;

      if (state_q == S_MEM && !bus.mem_ready) wait_q <= wait_q + 8'd1;
      else                                    wait_q <= '0;

      if (state_q == S_MEM && !bus.mem_ready && wait_last) mem_err_q <= 1'b1;

      // A step pulse seen while stopped is remembered until the next FETCH.
      if (state_d == S_FETCH)
        step_pend_q <= 1'b0;
      else if (bus.step && !bus.run && state_q != S_HALT)
        step_pend_q <= 1'b1;
    end
  end

  always_comb begin
    bus.pc_we      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_src    = 2'b00;
    bus.alu_src    = 1'b0;
    bus.alu_ctrl   = 2'b00;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.retired    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src  = op[2];
        bus.alu_ctrl = op[2] ? 2'b00 : op[1:0];
        bus.reg_src  = {is_str, is_b};
        if (is_b) begin
          bus.pc_we   = br_taken;
          bus.pc_src  = br_taken;
          bus.retired = 1'b1;
        end
      end
      // Address selects stay stable while the memory access is outstanding.
      S_MEM: begin
        bus.alu_src  = 1'b1;
        bus.alu_ctrl = 2'b00;
        bus.reg_src  = {is_str, 1'b0};
        bus.mem_re   = is_ldr;
        bus.mem_we   = is_str;
        bus.retired  = is_str && bus.mem_ready;
      end
      S_WB: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = is_ldr;
        bus.retired    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected control words are
// queued when an instruction is driven and compared as the sequencer steps through it.
module tb_multicycle_sequencer;

  localparam int MEM_TIMEOUT = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // Select fields (reg_src, alu_src, alu_ctrl) are only meaningful in EXEC.
  localparam logic [17:0] SEL_MASK = 18'h007C0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {state, pc_we, pc_src, ir_we, reg_we, reg_src, alu_src, alu_ctrl,
  //  mem_we, mem_re, mem_to_reg, retired, halted, mem_err}
  logic [17:0] obs;
  assign obs = {bus.state, bus.pc_we, bus.pc_src, bus.ir_we, bus.reg_we, bus.reg_src,
                bus.alu_src, bus.alu_ctrl, bus.mem_we, bus.mem_re, bus.mem_to_reg,
                bus.retired, bus.halted, bus.mem_err};

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [17:0] exp_q[$];
  logic [3:0]  model_flags;
  logic        model_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'b000:  return 1'b1;
      3'b001:  return f[2];
      3'b010:  return !f[2];
      3'b011:  return f[3] != f[0];
      3'b100:  return f[3] == f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [17:0] mk_word(input logic [2:0] st, input logic [15:0] ins,
                                          input logic taken, input logic ready);
    logic [17:0] w;
    logic [2:0]  op;
    op = ins[15:13];
    w = '0;
    w[17:15] = st;
    w[0] = model_err;
    case (st)
      ST_FETCH: begin w[14] = 1'b1; w[12] = 1'b1; end
      ST_EXEC: begin
        w[7:6] = (op < 3'd4) ? op[1:0] : 2'b00;
        w[8]   = (op >= 3'd4);
        w[10]  = (op == 3'd6);
        w[9]   = (op == 3'd7);
        if (op == 3'd7) begin
          w[14] = taken;
          w[13] = taken;
          w[2]  = 1'b1;
        end
      end
      ST_MEM: begin
        w[4] = (op == 3'd5);
        w[5] = (op == 3'd6);
        w[2] = (op == 3'd6) && ready;
      end
      ST_WB: begin
        w[11] = 1'b1;
        w[3]  = (op == 3'd5);
        w[2]  = 1'b1;
      end
      ST_HALT: w[1] = 1'b1;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  // Precondition: the next rising edge moves the sequencer into FETCH.
  // waits < 0 means mem_ready is never given (timeout path).
  task automatic exec_instr(input logic [15:0] ins, input int waits, input logic [3:0] fl,
                            input int drop_run_at, input int step_at);
    logic [2:0]  op;
    logic        taken;
    logic [17:0] e, m;
    int          n;
    op    = ins[15:13];
    taken = cond_true(ins[12:10], model_flags);
    exp_q.push_back(mk_word(ST_FETCH, ins, 1'b0, 1'b0));
    exp_q.push_back(mk_word(ST_DECODE, ins, 1'b0, 1'b0));
    if (op == 3'd7 && ins[12:10] == 3'd7) begin
      exp_q.push_back(mk_word(ST_HALT, ins, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk_word(ST_EXEC, ins, taken, 1'b0));
      if (op <= 3'd4) begin
        model_flags = fl;
        exp_q.push_back(mk_word(ST_WB, ins, 1'b0, 1'b0));
      end else if (op == 3'd5 || op == 3'd6) begin
        if (waits < 0) begin
          for (int k = 0; k < MEM_TIMEOUT; k++) exp_q.push_back(mk_word(ST_MEM, ins, 1'b0, 1'b0));
          model_err = 1'b1;
          exp_q.push_back(mk_word(ST_HALT, ins, 1'b0, 1'b0));
        end else begin
          for (int k = 0; k < waits; k++) exp_q.push_back(mk_word(ST_MEM, ins, 1'b0, 1'b0));
          exp_q.push_back(mk_word(ST_MEM, ins, 1'b0, 1'b1));
          if (op == 3'd5) exp_q.push_back(mk_word(ST_WB, ins, 1'b0, 1'b0));
        end
      end
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.instr     = ins;
      bus.alu_flags = fl;
      bus.step      = (i == step_at);
      if (i == drop_run_at) bus.run = 1'b0;
      bus.mem_ready = (op == 3'd5 || op == 3'd6) && (waits >= 0) && (i == 3 + waits);
      @(negedge clk);
      e = exp_q.pop_front();
      m = (e[17:15] == ST_EXEC) ? '1 : ~SEL_MASK;
      check($sformatf("instr %04h cyc %0d", ins, i), 32'(obs & m), 32'(e & m));
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.step      = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("idle", 32'(obs), 32'(mk_word(ST_IDLE, 16'h0, 1'b0, 1'b0)));
    end
  endtask

  task automatic halt_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.run       = 1'b1;
      bus.step      = i[0];
      bus.mem_ready = 1'b0;
      bus.instr     = 16'($urandom);
      @(negedge clk);
      check("halt_hold", 32'(obs), 32'(mk_word(ST_HALT, 16'h0, 1'b0, 1'b0)));
    end
  endtask

  task automatic do_reset();
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("reset_outputs", 32'(obs), 32'h0);
    model_flags = 4'h0;
    model_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run();
    @(posedge clk);
    #1;
    bus.run = 1'b1;
  endtask

  task automatic step_once();
    @(posedge clk);
    #1;
    bus.step = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] ins;
    logic [2:0]  op;
    logic        reached;
    rst_n         = 1'b1;
    bus.instr     = '0;
    bus.alu_flags = '0;
    bus.mem_ready = 1'b0;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    model_flags   = 4'h0;
    model_err     = 1'b0;

    do_reset();

    // Free-running directed sequence
    start_run();
    exec_instr(16'h0530, 0, 4'b0000, -1, -1);   // ADD
    exec_instr(16'h2530, 0, 4'b0100, -1, -1);   // SUB, Z=1
    exec_instr(16'hE405, 0, 4'b0000, -1, -1);   // B EQ taken
    exec_instr(16'hE805, 0, 4'b0100, -1, -1);   // B NE not taken
    exec_instr(16'hA4C2, 3, 4'b1111, -1, -1);   // LDR, 3 wait cycles
    exec_instr(16'hC4C2, 1, 4'b0000, -1, -1);   // STR, 1 wait cycle
    exec_instr(16'h8283, 0, 4'b1000, -1, -1);   // ADDI, N=1 V=0
    exec_instr(16'hEC05, 0, 4'b0000, -1, -1);   // B LT taken
    exec_instr(16'hF005, 0, 4'b1001, -1, -1);   // B GE not taken
    exec_instr(16'hF405, 0, 4'b0000, -1, -1);   // never
    exec_instr(16'h4530, 0, 4'b0010, -1, -1);   // AND
    exec_instr(16'h6530, 0, 4'b0001, -1, -1);   // ORR

    // Random instruction mix, run dropped during the last one
    for (int r = 0; r < 16; r++) begin
      ins = 16'($urandom);
      op  = 3'($urandom_range(0, 6 + (r % 2)));
      ins[15:13] = op;
      if (op == 3'd7) ins[12:10] = 3'($urandom_range(0, 6));
      exec_instr(ins, $urandom_range(0, 3), 4'($urandom), (r == 15) ? 1 : -1, -1);
    end
    idle_check(2);

    // Single-step: one instruction per pulse
    step_once();
    exec_instr(16'h0530, 0, 4'b0000, -1, -1);
    idle_check(3);
    step_once();
    exec_instr(16'hA4C2, 2, 4'b0000, -1, -1);
    idle_check(2);

    // Step pulse arriving mid-instruction is held until the next FETCH
    step_once();
    exec_instr(16'h8283, 0, 4'b0100, -1, 1);
    idle_check(1);
    exec_instr(16'h2530, 0, 4'b0000, -1, -1);
    idle_check(2);

    // Step while running is ignored; run dropped mid-instruction
    start_run();
    exec_instr(16'h0530, 0, 4'b0000, 2, 0);
    idle_check(3);

    // Asynchronous reset during a MEM wait
    start_run();
    reached = 1'b0;
    for (int k = 0; k < 12 && !reached; k++) begin
      @(posedge clk);
      #1;
      bus.instr     = 16'hA4C2;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      if (bus.state == ST_MEM) reached = 1'b1;
    end
    check("reach_mem", 32'(bus.state), 32'(ST_MEM));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_mem", 32'(obs), 32'h0);
    bus.run     = 1'b0;
    model_flags = 4'h0;
    model_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1);

    // HLT parks the sequencer
    start_run();
    exec_instr(16'hFC00, 0, 4'b0000, -1, -1);
    halt_check(4);
    do_reset();

    // Memory timeout on a store
    start_run();
    exec_instr(16'hC4C2, -1, 4'b0000, -1, -1);
    halt_check(4);
    do_reset();

    // Normal operation after recovery
    start_run();
    exec_instr(16'h0530, 0, 4'b0000, 0, -1);
    idle_check(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
